// File: rtl/pcs_am_pkg.sv
// Shared definitions for the PCS alignment-marker inserter.
// Holds the per-lane marker table, the AM sync header and the FSM encoding.
// Pure definitions: no logic, no latency, no flow control.
package pcs_am_pkg;

  // Number of lanes covered by the marker table below.
  localparam int AM_TABLE_LANES = 20;

  // Sync header carried by every alignment marker.
  localparam logic [1:0] AM_SYNC_HDR = 2'b01;

  // Inserter FSM states: a group of markers, then a period of data blocks.
  typedef enum logic [0:0] {
    AM_INSERT = 1'b0,
    DATA      = 1'b1
  } am_state_e;

  // Per-lane marker bytes {M0, M1, M2}, with M0 in the top byte.
  localparam logic [23:0] AM_MARKERS [AM_TABLE_LANES] = '{
    24'hC16821, 24'h9D718E, 24'h594BE8, 24'h4D957B, 24'hF50709,
    24'hDD14C2, 24'h9A4A26, 24'h7B4566, 24'hA02476, 24'h68C9FB,
    24'hFD6C99, 24'hB99155, 24'h5CB9B2, 24'h1AF8BD, 24'h83C7CA,
    24'h3536CD, 24'hC4314C, 24'hADD6B7, 24'h5F662A, 24'hC0F0E5
  };

  // Marker payload: M0,M1,M2,BIP3,M4,M5,M6,BIP7 with the second half inverted.
  function automatic logic [63:0] am_payload(input logic [23:0] marker,
                                             input logic [7:0]  bip3);
    return {marker, bip3, ~marker, ~bip3};
  endfunction

endpackage

// File: rtl/am_inserter_if.sv
// Block stream into the AM inserter and lane-tagged block stream out of it.
// Carries no state; latency is defined by the module that uses it.
// Upstream presents i_valid/i_data and may only count a block as taken while o_ready is high.
interface am_inserter_if #(
  parameter int LEN_CODED_BLOCK = 66,
  parameter int NB_LANE_ID      = 5
);

  logic                       i_valid;
  logic [LEN_CODED_BLOCK-1:0] i_data;
  logic                       o_ready;
  logic                       o_valid;
  logic [LEN_CODED_BLOCK-1:0] o_data;
  logic [NB_LANE_ID-1:0]      o_lane_id;
  logic                       o_am_flag;

  // Upstream / driver side.
  modport master (
    output i_valid, i_data,
    input  o_ready, o_valid, o_data, o_lane_id, o_am_flag
  );

  // Inserter side.
  modport slave (
    input  i_valid, i_data,
    output o_ready, o_valid, o_data, o_lane_id, o_am_flag
  );

endinterface

// File: rtl/am_bip_calc.sv
// Bit-interleaved parity of one 66b block into the 8 BIP lanes.
// Latency: combinational.
// Backpressure: none, pure function of the input block.
module am_bip_calc (
  input  logic [65:0] blk_i,
  output logic [7:0]  bip_o
);

  // Transmission order: blk_i[64] then blk_i[65] (sync header), then octet k
  // of the payload (blk_i[63-8k -: 8]) LSB first. Payload bit j of every
  // octet lands in BIP bit j; the two header bits land in BIP bits 3 and 4.
  always_comb begin
    bip_o = '0;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 8; j++) begin
        bip_o[j] = bip_o[j] ^ blk_i[56 - 8*k + j];
      end
    end
    bip_o[3] = bip_o[3] ^ blk_i[64];
    bip_o[4] = bip_o[4] ^ blk_i[65];
  end

endmodule

// File: rtl/am_inserter.sv
// Inserts a group of per-lane alignment markers every AM_PERIOD*N_LANES data blocks and tags lanes.
// Latency: one cycle from acceptance (or marker slot) to o_valid/o_data.
// Backpressure: o_ready is low for the whole marker group; i_valid is ignored then. Optional BIP: AM_INSERTER_BIP_EN.
module am_inserter
  import pcs_am_pkg::*;
#(
  parameter int LEN_CODED_BLOCK = 66,
  parameter int N_LANES         = 20,
  parameter int AM_PERIOD       = 16383,
  parameter int NB_LANE_ID      = 5
) (
  input  logic          i_clock,
  input  logic          i_reset,
  am_inserter_if.slave  bus
);

  // Blocks accepted between marker groups, counted across all lanes.
  localparam int BLK_TOTAL = AM_PERIOD * N_LANES;
  localparam int BLK_W     = (BLK_TOTAL > 1) ? $clog2(BLK_TOTAL) : 1;
  localparam logic [BLK_W-1:0]      BLK_LAST  = BLK_W'(BLK_TOTAL - 1);
  localparam logic [NB_LANE_ID-1:0] LANE_LAST = NB_LANE_ID'(N_LANES - 1);

  am_state_e                  state_q, state_d;
  logic [NB_LANE_ID-1:0]      am_idx_q, am_idx_d;
  logic [NB_LANE_ID-1:0]      lane_cnt_q, lane_cnt_d;
  logic [BLK_W-1:0]           blk_cnt_q, blk_cnt_d;

  logic                       o_valid_q, o_valid_d;
  logic [LEN_CODED_BLOCK-1:0] o_data_q, o_data_d;
  logic [NB_LANE_ID-1:0]      o_lane_id_q, o_lane_id_d;
  logic                       o_am_flag_q, o_am_flag_d;

  // The block leaving this cycle (marker or accepted data) and its lane.
  logic                       emit_vld;
  logic                       emit_am;
  logic [NB_LANE_ID-1:0]      emit_lane;
  logic [LEN_CODED_BLOCK-1:0] emit_dat;
  logic [7:0]                 bip3;

`ifdef AM_INSERTER_BIP_EN
  // One running parity per lane; seeded by the lane's marker as it goes out,
  // so the value placed in the next marker spans that marker plus the data after it.
  logic [7:0] bip_acc_q [N_LANES];
  logic [7:0] emit_bip;

  am_bip_calc u_bip_calc (
    .blk_i (emit_dat[65:0]),
    .bip_o (emit_bip)
  );

  // Fold each emitted block into its lane's parity; a marker restarts it.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int l = 0; l < N_LANES; l++) begin
        bip_acc_q[l] <= '0;
      end
    end else if (emit_vld) begin
      if (emit_am) begin
        bip_acc_q[emit_lane] <= emit_bip;
      end else begin
        bip_acc_q[emit_lane] <= bip_acc_q[emit_lane] ^ emit_bip;
      end
    end
  end

  assign bip3 = bip_acc_q[am_idx_q];
`else
  // Without parity tracking the marker carries BIP3=00 and BIP7=FF.
  assign bip3 = 8'h00;
`endif

  // Next-state, counter and emission decode for the marker/data FSM.
  always_comb begin
    state_d    = state_q;
    am_idx_d   = am_idx_q;
    lane_cnt_d = lane_cnt_q;
    blk_cnt_d  = blk_cnt_q;
    emit_vld   = 1'b0;
    emit_am    = 1'b0;
    emit_lane  = lane_cnt_q;
    emit_dat   = bus.i_data;

    unique case (state_q)
      AM_INSERT: begin
        // One marker per cycle regardless of upstream; markers bypass scrambling.
        emit_vld  = 1'b1;
        emit_am   = 1'b1;
        emit_lane = am_idx_q;
        emit_dat  = LEN_CODED_BLOCK'({AM_SYNC_HDR,
                                      am_payload(AM_MARKERS[am_idx_q], bip3)});
        if (am_idx_q == LANE_LAST) begin
          am_idx_d = '0;
          state_d  = DATA;
        end else begin
          am_idx_d = am_idx_q + 1'b1;
        end
      end

      DATA: begin
        if (bus.i_valid) begin
          emit_vld  = 1'b1;
          emit_lane = lane_cnt_q;
          emit_dat  = bus.i_data;
          if (blk_cnt_q == BLK_LAST) begin
            // Last block of the period: restart lanes and go insert markers.
            blk_cnt_d  = '0;
            lane_cnt_d = '0;
            state_d    = AM_INSERT;
          end else begin
            blk_cnt_d  = blk_cnt_q + 1'b1;
            lane_cnt_d = (lane_cnt_q == LANE_LAST) ? '0 : lane_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = AM_INSERT;
      end
    endcase
  end

  // Output stage: valid follows emission every cycle, payload holds when idle.
  always_comb begin
    o_valid_d   = emit_vld;
    o_data_d    = o_data_q;
    o_lane_id_d = o_lane_id_q;
    o_am_flag_d = o_am_flag_q;
    if (emit_vld) begin
      o_data_d    = emit_dat;
      o_lane_id_d = emit_lane;
      o_am_flag_d = emit_am;
    end
  end

  // State, counters and output registers; reset restarts with the lane-0 marker.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= AM_INSERT;
      am_idx_q    <= '0;
      lane_cnt_q  <= '0;
      blk_cnt_q   <= '0;
      o_valid_q   <= 1'b0;
      o_data_q    <= '0;
      o_lane_id_q <= '0;
      o_am_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      am_idx_q    <= am_idx_d;
      lane_cnt_q  <= lane_cnt_d;
      blk_cnt_q   <= blk_cnt_d;
      o_valid_q   <= o_valid_d;
      o_data_q    <= o_data_d;
      o_lane_id_q <= o_lane_id_d;
      o_am_flag_q <= o_am_flag_d;
    end
  end

  assign bus.o_ready   = (state_q == DATA);
  assign bus.o_valid   = o_valid_q;
  assign bus.o_data    = o_data_q;
  assign bus.o_lane_id = o_lane_id_q;
  assign bus.o_am_flag = o_am_flag_q;

endmodule

// File: doc/am_inserter.md
AM_INSERTER -- requirements
Module: am_inserter

Interface
REQ-001 SHALL have parameter LEN_CODED_BLOCK, default 66, giving the width of the coded block.
REQ-002 SHALL have parameter N_LANES, default 20, giving the number of PCS lanes.
REQ-003 SHALL have parameter AM_PERIOD, default 16383, giving the number of data blocks per lane between alignment-marker (AM) groups.
REQ-004 SHALL have parameter NB_LANE_ID, default 5, giving the width of the lane index.
REQ-005 SHALL use one clock and a synchronous, active-high reset: i_clock  in  1  rising-edge clock.
REQ-006 i_reset  in  1  synchronous, active-high reset.
REQ-007 i_valid  in  1  upstream (scrambler output) block valid.
REQ-008 i_data  in  LEN_CODED_BLOCK  scrambled 66b block; sync header in [65:64].
REQ-009 o_ready  out  1  block accepted this cycle when high; upstream gates its enable with it.
REQ-010 o_valid  out  1  o_data valid.
REQ-011 o_data  out  LEN_CODED_BLOCK  data block or AM.
REQ-012 o_lane_id  out  NB_LANE_ID  destination PCS lane of o_data.
REQ-013 o_am_flag  out  1  o_data is an AM.

Function
REQ-014 SHALL implement FSM states AM_INSERT and DATA; o_ready = (state==DATA), decoded from the state register.
REQ-015 In DATA with i_valid=1, SHALL register o_data=i_data, o_lane_id=lane_cnt, o_valid=1, o_am_flag=0 (1-cycle latency), then advance lane_cnt modulo N_LANES and increment blk_cnt.
REQ-016 In DATA with i_valid=0, SHALL drive o_valid=0 and hold all counters.
REQ-017 On acceptance of block number AM_PERIOD*N_LANES (blk_cnt at terminal), SHALL clear blk_cnt and lane_cnt and enter AM_INSERT on the next cycle.
REQ-018 In AM_INSERT, SHALL emit one AM per cycle for am_idx 0..N_LANES-1 with o_valid=1, o_am_flag=1, o_lane_id=am_idx, and enter DATA after am_idx=N_LANES-1.
REQ-019 In AM_INSERT, SHALL ignore i_valid: no capture and no counter change.
REQ-020 AM format SHALL be o_data[65:64]=2'b01, with [63:0] = M0,M1,M2,BIP3,M4,M5,M6,BIP7 (M0 in [63:56]), where M4..M6 = ~M0..M2 and BIP7 = ~BIP3.
REQ-021 Mx values SHALL follow IEEE 802.3 Table 82-2 (lane 0: C1,68,21; lane 1: 9D,71,8E; ...).
REQ-022 AMs SHALL NOT be scrambled.
REQ-023 Output registers SHALL update every cycle: o_valid is deasserted on cycles without an emission, and o_data, o_lane_id and o_am_flag hold their last values.

Reset
REQ-024 On i_reset, SHALL set state=AM_INSERT, am_idx=0, lane_cnt=0, blk_cnt=0, all BIP accumulators=0, o_valid=0, o_am_flag=0, o_lane_id=0, o_data=0.
REQ-025 Reset mid-group or mid-period SHALL abort the operation; the first cycle after release SHALL emit the lane-0 AM.

Configuration
REQ-026 With macro AM_INSERTER_BIP_EN defined, SHALL keep a per-lane 8-bit BIP accumulator updated with every block emitted on that lane (IEEE 802.3 82.2.8 bit mapping, including the sync header).
REQ-027 With AM_INSERTER_BIP_EN defined, the accumulator SHALL cover the lane's previous AM, and SHALL be reloaded from the lane's AM as emitted; BIP3 SHALL equal the accumulator.
REQ-028 Without AM_INSERTER_BIP_EN, SHALL drive BIP3=8'h00 and BIP7=8'hFF and instantiate no accumulators.

Structure
REQ-029 Shared package pcs_am_pkg SHALL hold the N_LANES x 24-bit AM marker table, the AM sync header constant 2'b01, and the FSM state encoding.
REQ-030 Sub-module am_bip_calc (combinational 66b -> 8b parity per 82.2.8) SHALL be instantiated only under AM_INSERTER_BIP_EN.

Verification (sim params AM_PERIOD=4, N_LANES=20)
REQ-031 Release reset, hold i_valid=1 -> 20 cycles of o_am_flag=1, lanes 0..19, o_ready=0; lane 0 o_data=66'h1_C168_2100_3E97_DEFF (BIP off).
REQ-032 Then 80 accepted blocks -> o_lane_id 0..19 repeating 4 times with o_data equal to the input delayed 1 cycle; o_ready=0 from the cycle after the 80th accept for 20 cycles.
REQ-033 i_valid pulses while o_ready=0 -> no o_valid from them; block count unchanged (next AM group still after 80 accepts).
REQ-034 Random i_valid gaps in DATA -> o_valid tracks accepts; lane sequence is unbroken.
REQ-035 Reset at am_idx=7 -> after release, first output is the lane-0 AM and counters restart.
REQ-036 BIP_EN, i_data=66'h2_0000_0000_0000_0000 for all blocks -> each AM's BIP3 matches the golden model and BIP7=~BIP3 on every lane.
